// File: rtl/adc_frame_reader.sv
// Drains the ADC sample FIFO into framed byte packets: sync, channel, 16-bit
// length, FRAME_LEN samples and an 8-bit sample checksum, over valid/ready.
module adc_frame_reader #(
  parameter int unsigned FRAME_LEN = 512,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [7:0]  CH_ID     = 8'h00
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic [7:0] fifo_q,
  input  logic       fifo_empty,
  output logic       fifo_rdreq,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [15:0] LEN = 16'(FRAME_LEN);

  typedef enum logic [3:0] {
    IDLE, SYNC, CHAN, LEN_H, LEN_L, FETCH, WAIT_Q, SEND, CSUM, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  sample_q, sample_d;

  assign cnt_inc = cnt_q + 16'd1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      csum_q   <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      sample_q <= sample_d;
    end
  end

  // Outputs decode from the state register so an async reset clears them at once;
  // tx_data only changes on a state change, which needs a handshake while valid.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    sample_d   = sample_q;
    fifo_rdreq = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = SYNC;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) state_d = CHAN;
      end
      CHAN: begin
        tx_valid = 1'b1;
        tx_data  = CH_ID;
        if (tx_ready) state_d = LEN_H;
      end
      LEN_H: begin
        tx_valid = 1'b1;
        tx_data  = LEN[15:8];
        if (tx_ready) state_d = LEN_L;
      end
      LEN_L: begin
        tx_valid = 1'b1;
        tx_data  = LEN[7:0];
        if (tx_ready) state_d = FETCH;
      end
      FETCH: begin
        if (!fifo_empty) begin
          fifo_rdreq = 1'b1;
          state_d    = WAIT_Q;
        end
      end
      WAIT_Q: begin
        sample_d = fifo_q;
        csum_d   = csum_q + fifo_q;
        state_d  = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = sample_q;
        if (tx_ready) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == LEN) ? CSUM : FETCH;
        end
      end
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) state_d = DONE;
      end
      DONE: begin
        busy       = 1'b0;
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_frame_reader.sv
// Directed bench for adc_frame_reader: a FRAME_LEN=4 and a FRAME_LEN=3 instance
// share one FIFO model and byte monitor, selected by sel.
module tb_adc_frame_reader;
  logic       Clk = 0, Reset_n = 0, start = 0, tx_ready = 0, sel = 0;
  logic [7:0] fq = 0;
  logic [7:0] mem [0:63];
  logic [5:0] rd_ptr = 0, wr_ptr = 0;
  logic       fifo_empty;
  logic       rd4, v4, b4, d4, rd3, v3, b3, d3;
  logic [7:0] t4, t3;
  logic       m_rdreq, m_valid, m_busy, m_done;
  logic [7:0] m_data;
  int checks = 0, errors = 0;
  int rd_cnt = 0, rd_empty_err = 0, done_cnt = 0, stall_err = 0;
  bit busy_at_done = 0, prev_stall = 0;
  logic [7:0] prev_data = 0;
  logic [7:0] bytes [$];

  always #5 Clk = ~Clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  adc_frame_reader #(.FRAME_LEN(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start && !sel), .fifo_q(fq),
    .fifo_empty(fifo_empty || sel), .fifo_rdreq(rd4), .tx_data(t4), .tx_valid(v4),
    .tx_ready(tx_ready), .busy(b4), .frame_done(d4));

  adc_frame_reader #(.FRAME_LEN(3)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start && sel), .fifo_q(fq),
    .fifo_empty(fifo_empty || !sel), .fifo_rdreq(rd3), .tx_data(t3), .tx_valid(v3),
    .tx_ready(tx_ready), .busy(b3), .frame_done(d3));

  assign m_rdreq = sel ? rd3 : rd4;
  assign m_valid = sel ? v3 : v4;
  assign m_data  = sel ? t3 : t4;
  assign m_busy  = sel ? b3 : b4;
  assign m_done  = sel ? d3 : d4;

  // Non-show-ahead FIFO: data appears the cycle after rdreq.
  always @(posedge Clk) begin
    if (m_rdreq) begin
      fq     <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 6'd1;
    end
  end

  always @(posedge Clk) begin
    if (Reset_n) begin
      if (m_valid && tx_ready) bytes.push_back(m_data);
      if (m_rdreq) rd_cnt++;
      if (m_rdreq && fifo_empty) rd_empty_err++;
      if (m_done) begin done_cnt++; busy_at_done = m_busy; end
      if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err++;
      prev_stall = m_valid && !tx_ready;
      prev_data  = m_data;
    end else prev_stall = 0;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic start_pulse();
    @(negedge Clk); start = 1;
    @(negedge Clk); start = 0;
  endtask

  task automatic run_until_done(input int budget, output bit to);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin @(negedge Clk); n++; end
    to = (done_cnt == d0);
  endtask

  task automatic test_reset();
    Reset_n = 0; start = 0; tx_ready = 0;
    repeat (3) @(negedge Clk);
    checks += 5;
    if (rd4 !== 1'b0) begin errors++; $display("FAIL reset_rdreq got %b want 0", rd4); end
    if (v4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", v4); end
    if (t4 !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", t4); end
    if (b4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b4); end
    if (d4 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", d4); end
    Reset_n = 1;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp [9] = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
    int r0 = rd_cnt, d0 = done_cnt;
    bit to;
    bytes.delete();
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    tx_ready = 1;
    start_pulse();
    checks++;
    if (m_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b want 1", m_busy); end
    run_until_done(200, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout got timeout want frame_done"); end
    repeat (5) @(negedge Clk);
    checks += 4;
    if (bytes.size() != 9) begin errors++; $display("FAIL basic_len got %0d want 9", bytes.size()); end
    if (rd_cnt - r0 != 4) begin errors++; $display("FAIL basic_rdreq got %0d want 4", rd_cnt - r0); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got %0d want 1", done_cnt - d0); end
    if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy_at_done); end
    for (int i = 0; i < 9 && i < bytes.size(); i++) begin
      checks++;
      if (bytes[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, bytes[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [9] = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
    int n = 0, d0 = done_cnt, s0 = stall_err;
    bit held = 0;
    bytes.delete();
    tx_ready = 0;
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    start_pulse();
    while (done_cnt == d0 && n < 400) begin
      if (!held && bytes.size() >= 5 && m_valid) begin
        tx_ready = 0;
        repeat (5) @(negedge Clk);
        held = 1; n += 5;
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b want 1", m_valid); end
      end else begin
        tx_ready = ~tx_ready;
        @(negedge Clk); n++;
      end
    end
    tx_ready = 1;
    repeat (3) @(negedge Clk);
    checks += 3;
    if (done_cnt == d0) begin errors++; $display("FAIL bp_timeout got timeout want frame_done"); end
    if (stall_err != s0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stall_err - s0); end
    if (bytes.size() != 9) begin errors++; $display("FAIL bp_len got %0d want 9", bytes.size()); end
    for (int i = 0; i < 9 && i < bytes.size(); i++) begin
      checks++;
      if (bytes[i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, bytes[i], exp[i]); end
    end
  endtask

  task automatic test_empty_stall();
    logic [7:0] exp [9] = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    int r0 = rd_cnt, e0 = rd_empty_err;
    bit to;
    bytes.delete();
    tx_ready = 1;
    push(8'h01); push(8'h02);
    start_pulse();
    repeat (20) @(negedge Clk);
    checks += 3;
    if (rd_cnt - r0 != 2) begin errors++; $display("FAIL empty_rdreq got %0d want 2", rd_cnt - r0); end
    if (bytes.size() != 6) begin errors++; $display("FAIL empty_partial got %0d want 6", bytes.size()); end
    if (m_busy !== 1'b1) begin errors++; $display("FAIL empty_busy got %b want 1", m_busy); end
    push(8'h03); push(8'h04);
    run_until_done(200, to);
    repeat (2) @(negedge Clk);
    checks += 3;
    if (to) begin errors++; $display("FAIL empty_timeout got timeout want frame_done"); end
    if (rd_empty_err != e0) begin errors++; $display("FAIL empty_read got %0d want 0", rd_empty_err - e0); end
    if (bytes.size() != 9) begin errors++; $display("FAIL empty_len got %0d want 9", bytes.size()); end
    for (int i = 0; i < 9 && i < bytes.size(); i++) begin
      checks++;
      if (bytes[i] !== exp[i]) begin errors++; $display("FAIL empty_byte%0d got %h want %h", i, bytes[i], exp[i]); end
    end
  endtask

  task automatic test_start_busy();
    int n = 0, d0 = done_cnt;
    bytes.delete();
    tx_ready = 1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    start_pulse();
    while (bytes.size() < 5 && n < 100) begin @(negedge Clk); n++; end
    start_pulse();
    repeat (40) @(negedge Clk);
    checks += 4;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL sb_done got %0d want 1", done_cnt - d0); end
    if (bytes.size() != 9) begin errors++; $display("FAIL sb_len got %0d want 9", bytes.size()); end
    if (m_busy !== 1'b0) begin errors++; $display("FAIL sb_busy got %b want 0", m_busy); end
    if (bytes.size() == 9 && bytes[8] !== 8'hAA) begin errors++; $display("FAIL sb_csum got %h want aa", bytes[8]); end
  endtask

  task automatic test_csum_wrap();
    logic [7:0] exp [8] = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'h03, 8'h01};
    bit to;
    @(negedge Clk); sel = 1;
    bytes.delete();
    tx_ready = 1;
    push(8'hFF); push(8'hFF); push(8'h03);
    start_pulse();
    run_until_done(200, to);
    repeat (2) @(negedge Clk);
    checks += 2;
    if (to) begin errors++; $display("FAIL wrap_timeout got timeout want frame_done"); end
    if (bytes.size() != 8) begin errors++; $display("FAIL wrap_len got %0d want 8", bytes.size()); end
    for (int i = 0; i < 8 && i < bytes.size(); i++) begin
      checks++;
      if (bytes[i] !== exp[i]) begin errors++; $display("FAIL wrap_byte%0d got %h want %h", i, bytes[i], exp[i]); end
    end
    sel = 0;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [9] = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h66, 8'h77, 8'h88, 8'h99, 8'hFE};
    int n = 0;
    bit to;
    bytes.delete();
    tx_ready = 1;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    start_pulse();
    while (!(bytes.size() == 4 && m_valid) && n < 100) begin
      if (bytes.size() >= 4) tx_ready = 0;
      @(negedge Clk); n++;
    end
    checks++;
    if (m_data !== 8'h55) begin errors++; $display("FAIL rst_send_data got %h want 55", m_data); end
    Reset_n = 0;
    #1;
    checks += 5;
    if (rd4 !== 1'b0) begin errors++; $display("FAIL rst_mid_rdreq got %b want 0", rd4); end
    if (v4 !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", v4); end
    if (t4 !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h want 00", t4); end
    if (b4 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", b4); end
    if (d4 !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", d4); end
    @(negedge Clk); Reset_n = 1;
    bytes.delete();
    push(8'h99);
    tx_ready = 1;
    repeat (4) @(negedge Clk);
    checks += 2;
    if (bytes.size() != 0) begin errors++; $display("FAIL rst_replay got %0d bytes want 0", bytes.size()); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got %b want 0", m_valid); end
    start_pulse();
    run_until_done(200, to);
    repeat (2) @(negedge Clk);
    checks += 2;
    if (to) begin errors++; $display("FAIL rst_timeout got timeout want frame_done"); end
    if (bytes.size() != 9) begin errors++; $display("FAIL rst_len got %0d want 9", bytes.size()); end
    for (int i = 0; i < 9 && i < bytes.size(); i++) begin
      checks++;
      if (bytes[i] !== exp[i]) begin errors++; $display("FAIL rst_byte%0d got %h want %h", i, bytes[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_start_busy();
    test_csum_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
